// File: rtl/sseg_mux_driver_if.sv
// Bundle of the display driver's data inputs and display-pin outputs.
// The master side is the datapath feeding digits; the slave side is the driver.
interface sseg_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] hex_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic                    lzb_i;
  logic                    en_i;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [6:0]              sseg_o;
  logic                    dp_o;
  logic                    frame_o;

  modport master (
    output hex_i, dp_i, blank_i, lzb_i, en_i,
    input  an_o, sseg_o, dp_o, frame_o
  );

  modport slave (
    input  hex_i, dp_i, blank_i, lzb_i, en_i,
    output an_o, sseg_o, dp_o, frame_o
  );
endinterface

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment driver for a common-anode display: per-slot
// guard interval, frame-synchronous input snapshot, leading-zero blanking.
module sseg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  sseg_if.slave  bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_hex_q, snap_hex_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic                    snap_lzb_q, snap_lzb_d;
  logic                    snap_vld_q, snap_vld_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              sseg_q, sseg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic                    slot_end;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic                    zacc;
  logic [3:0]              nibble;
  logic                    digit_blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = bus.en_i && (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_hex_d   = snap_hex_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    snap_lzb_d   = snap_lzb_q;
    snap_vld_d   = snap_vld_q;
    if (bus.en_i) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) idx_d = idx_q + 1'b1;
      if (frame_end) begin
        idx_d        = '0;
        snap_hex_d   = bus.hex_i;
        snap_dp_d    = bus.dp_i;
        snap_blank_d = bus.blank_i;
        snap_lzb_d   = bus.lzb_i;
        snap_vld_d   = 1'b1;
      end
    end
  end

  // zero_above[i]: every snapshot nibble from the top digit down to i is zero
  always_comb begin
    zacc       = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc          = zacc & (snap_hex_q[4*i +: 4] == 4'h0);
      zero_above[i] = zacc;
    end
  end

  assign nibble      = snap_hex_q[{idx_q, 2'b00} +: 4];
  assign digit_blank = snap_blank_q[idx_q] ||
                       (snap_lzb_q && (idx_q != '0) && zero_above[idx_q]);

  // Until the first snapshot is taken there is no data, so anodes stay off too.
  always_comb begin
    an_d    = '1;
    sseg_d  = 7'h7F;
    dp_d    = 1'b1;
    frame_d = frame_end;
    if (bus.en_i && snap_vld_q && (cnt_q >= GUARD_C)) begin
      an_d[idx_q] = 1'b0;
      dp_d        = ~snap_dp_q[idx_q];
      sseg_d      = digit_blank ? 7'h7F : decode(nibble);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_hex_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '1;
      snap_lzb_q   <= 1'b0;
      snap_vld_q   <= 1'b0;
      an_q         <= '1;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_hex_q   <= snap_hex_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      snap_lzb_q   <= snap_lzb_d;
      snap_vld_q   <= snap_vld_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.an_o    = an_q;
  assign bus.sseg_o  = sseg_q;
  assign bus.dp_o    = dp_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver with a 4-digit, 4-cycle-slot, 1-guard setup.
module tb_sseg_mux_driver;
  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  sseg_if #(.NUM_DIGITS(4)) bus ();

  sseg_mux_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 32'(bus.an_o), 32'h0F);
    chk({tag, "_seg"}, 32'(bus.sseg_o), 32'h7F);
    chk({tag, "_dp"}, 32'(bus.dp_o), 32'h1);
  endtask

  // Starts one cycle after a slot boundary edge; ends on the next boundary edge.
  task automatic slot(input string tag, input int d, input logic [6:0] seg, input logic dpx);
    logic [3:0] an_e;
    an_e    = 4'b1111;
    an_e[d] = 1'b0;
    tick();
    chk_dark({tag, "_guard"});
    tick();
    chk({tag, "_an"}, 32'(bus.an_o), 32'(an_e));
    chk({tag, "_seg"}, 32'(bus.sseg_o), 32'(seg));
    chk({tag, "_dp"}, 32'(bus.dp_o), 32'(dpx));
    tick();
    chk({tag, "_an_hold"}, 32'(bus.an_o), 32'(an_e));
    tick();
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (bus.frame_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_frame"}, 32'(bus.frame_o), 32'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.hex_i   = 16'h1234;
    bus.dp_i    = 4'b0010;
    bus.blank_i = 4'b0000;
    bus.lzb_i   = 1'b0;
    bus.en_i    = 1'b1;

    #23;
    chk_dark("rst");
    chk("rst_frame", 32'(bus.frame_o), 32'h0);
    #5 rst_n = 1'b1;

    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_dark("f0");
      chk("f0_noframe", 32'(bus.frame_o), 32'h0);
    end
    tick();
    chk("f0_frame", 32'(bus.frame_o), 32'h1);
    chk_dark("f0_end");

    bus.hex_i = 16'hABCF;
    slot("f1_d0", 0, 7'b0011001, 1'b1);
    slot("f1_d1", 1, 7'b0110000, 1'b0);
    slot("f1_d2", 2, 7'b0100100, 1'b1);
    slot("f1_d3", 3, 7'b1111001, 1'b1);

    wait_frame("f2");
    bus.lzb_i = 1'b1;
    bus.hex_i = 16'h0042;
    bus.dp_i  = 4'b0000;
    slot("f2_d0", 0, 7'b0001110, 1'b1);
    slot("f2_d1", 1, 7'b1000110, 1'b0);
    slot("f2_d2", 2, 7'b0000011, 1'b1);
    slot("f2_d3", 3, 7'b0001000, 1'b1);

    wait_frame("f3");
    bus.hex_i = 16'h0000;
    slot("f3_d0", 0, 7'b0100100, 1'b1);
    slot("f3_d1", 1, 7'b0011001, 1'b1);
    slot("f3_d2", 2, 7'b1111111, 1'b1);
    slot("f3_d3", 3, 7'b1111111, 1'b1);

    wait_frame("f4");
    bus.lzb_i = 1'b0;
    bus.hex_i = 16'h1234;
    slot("f4_d0", 0, 7'b1000000, 1'b1);
    slot("f4_d1", 1, 7'b1111111, 1'b1);
    slot("f4_d2", 2, 7'b1111111, 1'b1);
    slot("f4_d3", 3, 7'b1111111, 1'b1);

    wait_frame("f5");
    slot("f5_d0", 0, 7'b0011001, 1'b1);
    bus.hex_i = 16'h5678;
    slot("f5_d1", 1, 7'b0110000, 1'b1);
    slot("f5_d2", 2, 7'b0100100, 1'b1);
    slot("f5_d3", 3, 7'b1111001, 1'b1);

    wait_frame("f6");
    bus.blank_i = 4'b0100;
    bus.dp_i    = 4'b0100;
    slot("f6_d0", 0, 7'b0000000, 1'b1);
    slot("f6_d1", 1, 7'b1111000, 1'b1);
    slot("f6_d2", 2, 7'b0000010, 1'b1);
    slot("f6_d3", 3, 7'b0010010, 1'b1);

    wait_frame("f7");
    bus.blank_i = 4'b0000;
    bus.dp_i    = 4'b0000;
    slot("f7_d0", 0, 7'b0000000, 1'b1);
    slot("f7_d1", 1, 7'b1111000, 1'b1);
    tick();
    chk_dark("f7_d2_guard");
    tick();
    chk("f7_d2_an", 32'(bus.an_o), 32'b1011);
    chk("f7_d2_seg", 32'(bus.sseg_o), 32'h7F);
    chk("f7_d2_dp", 32'(bus.dp_o), 32'h0);
    bus.en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_dark("pause");
      chk("pause_noframe", 32'(bus.frame_o), 32'h0);
    end
    bus.en_i = 1'b1;
    tick();
    chk("resume_an", 32'(bus.an_o), 32'b1011);
    chk("resume_dp", 32'(bus.dp_o), 32'h0);
    tick();
    chk("resume_an2", 32'(bus.an_o), 32'b1011);
    chk("resume_noframe2", 32'(bus.frame_o), 32'h0);
    tick();
    chk_dark("resume_d3_guard");
    chk("resume_noframe3", 32'(bus.frame_o), 32'h0);
    tick();
    chk("resume_d3_an", 32'(bus.an_o), 32'b0111);
    chk("resume_d3_seg", 32'(bus.sseg_o), 32'b0010010);
    chk("resume_noframe4", 32'(bus.frame_o), 32'h0);
    tick();
    chk("resume_noframe5", 32'(bus.frame_o), 32'h0);
    tick();
    chk("resume_frame_shift", 32'(bus.frame_o), 32'h1);

    tick();
    tick();
    chk("pre_rst_an", 32'(bus.an_o), 32'b1110);
    chk("pre_rst_seg", 32'(bus.sseg_o), 32'b0000000);
    #2 rst_n = 1'b0;
    #1;
    chk_dark("async_rst");
    chk("async_rst_frame", 32'(bus.frame_o), 32'h0);
    tick();
    chk_dark("async_rst_hold");
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
